// File: rtl/mem_pipeline_q.sv
// In-order memory stage: DEPTH-entry request FIFO, one cache request in flight, registered result slot.
// Optional misalignment faulting is enabled by defining MEM_PIPE_ALIGN_CHK_EN.
`timescale 1ns/1ps
module mem_pipeline_q #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 8,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_op,
   input  logic [1:0]        in_size,
   input  logic              in_signed,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [63:0]       in_wdata,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TAG_W-1:0]  out_tag,
   output logic [63:0]       out_data,
   output logic              out_fault,
   output logic [1:0]        cache_req_type,
   output logic [ADDR_W-1:0] req_addr,
   output logic [63:0]       req_data,
   output logic [7:0]        req_be,
   input  logic              mem_respcyc,
   input  logic [63:0]       resp_data
);

   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [1:0] OP_MNOP  = 2'd0;
   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_STORE = 2'd2;

   localparam logic [1:0] REQ_IDLE  = 2'd0;
   localparam logic [1:0] REQ_READ  = 2'd1;
   localparam logic [1:0] REQ_WRITE = 2'd2;
   localparam logic [1:0] REQ_FLUSH = 2'd3;

   typedef struct packed {
      logic [1:0]        op;
      logic [1:0]        size;
      logic              sgn;
      logic [ADDR_W-1:0] addr;
      logic [63:0]       wdata;
      logic [TAG_W-1:0]  tag;
   } entry_t;

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   function automatic logic [7:0] size_mask(input logic [1:0] size);
      case (size)
         2'd0:    size_mask = 8'h01;
         2'd1:    size_mask = 8'h03;
         2'd2:    size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

   // Bits shifted past lane 7 fall off, which is the intended truncation.
   function automatic logic [7:0] byte_enables(input logic [1:0] size, input logic [2:0] off);
      byte_enables = size_mask(size) << off;
   endfunction

   function automatic logic [63:0] extract_load(input logic [63:0] word, input logic [2:0] off,
                                                input logic [1:0] size, input logic sgn);
      logic [63:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         2'd0:    extract_load = sgn ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
         2'd1:    extract_load = sgn ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
         2'd2:    extract_load = sgn ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
         default: extract_load = sh;
      endcase
   endfunction

`ifdef MEM_PIPE_ALIGN_CHK_EN
   function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] size,
                                          input logic [2:0] off);
      logic bad;
      case (size)
         2'd0:    bad = 1'b0;
         2'd1:    bad = off[0];
         2'd2:    bad = |off[1:0];
         default: bad = |off;
      endcase
      is_misaligned = bad && ((op == OP_LOAD) || (op == OP_STORE));
   endfunction
`endif

   entry_t              fifo_q [DEPTH];
   entry_t              fifo_d [DEPTH];
   logic [PTR_W:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   state_t              state_q, state_d;
   logic                out_valid_q, out_valid_d, out_fault_q, out_fault_d;
   logic [TAG_W-1:0]    out_tag_q, out_tag_d;
   logic [63:0]         out_data_q, out_data_d, req_data_q, req_data_d;
   logic [1:0]          req_type_q, req_type_d;
   logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
   logic [7:0]          req_be_q, req_be_d;

   entry_t              head_s;
   logic                empty_s, full_s, push_s, pop_s, slot_free_s, bad_s;
   logic                res_load_s, res_fault_s;
   logic [63:0]         res_data_s;

   assign head_s      = fifo_q[rd_ptr_q[PTR_W-1:0]];
   assign empty_s     = (wr_ptr_q == rd_ptr_q);
   assign full_s      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign push_s      = in_valid && !full_s;
   assign slot_free_s = !out_valid_q || out_ready;

`ifdef MEM_PIPE_ALIGN_CHK_EN
   assign bad_s = is_misaligned(head_s.op, head_s.size, head_s.addr[2:0]);
`else
   assign bad_s = 1'b0;
`endif

   // Issue FSM: MNOPs and faulting ops retire straight from IDLE; real ops hold the request until the response.
   always_comb begin
      state_d     = state_q;
      pop_s       = 1'b0;
      res_load_s  = 1'b0;
      res_fault_s = 1'b0;
      res_data_s  = 64'd0;
      req_type_d  = req_type_q;
      req_addr_d  = req_addr_q;
      req_data_d  = req_data_q;
      req_be_d    = req_be_q;
      case (state_q)
         S_IDLE: begin
            if (!empty_s && slot_free_s) begin
               if ((head_s.op == OP_MNOP) || bad_s) begin
                  pop_s       = 1'b1;
                  res_load_s  = 1'b1;
                  res_fault_s = bad_s;
               end else begin
                  state_d    = S_WAIT;
                  req_addr_d = {head_s.addr[ADDR_W-1:3], 3'b000};
                  case (head_s.op)
                     OP_LOAD:  req_type_d = REQ_READ;
                     OP_STORE: req_type_d = REQ_WRITE;
                     default:  req_type_d = REQ_FLUSH;
                  endcase
                  if (head_s.op == OP_STORE) begin
                     req_data_d = head_s.wdata << {head_s.addr[2:0], 3'b000};
                     req_be_d   = byte_enables(head_s.size, head_s.addr[2:0]);
                  end else begin
                     req_data_d = 64'd0;
                     req_be_d   = 8'd0;
                  end
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (mem_respcyc) begin
               state_d    = S_IDLE;
               pop_s      = 1'b1;
               res_load_s = 1'b1;
               req_type_d = REQ_IDLE;
               req_addr_d = '0;
               req_data_d = 64'd0;
               req_be_d   = 8'd0;
               if (head_s.op == OP_LOAD) begin
                  res_data_s = extract_load(resp_data, head_s.addr[2:0], head_s.size, head_s.sgn);
               end else begin
                  res_data_s = 64'd0;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         default: begin
            state_d    = S_IDLE;
            req_type_d = REQ_IDLE;
            req_be_d   = 8'd0;
         end
      endcase
   end

   // Result slot, FIFO pointers and storage next-state.
   always_comb begin
      if (res_load_s) begin
         out_valid_d = 1'b1;
         out_tag_d   = head_s.tag;
         out_data_d  = res_data_s;
         out_fault_d = res_fault_s;
      end else begin
         out_valid_d = out_valid_q && !out_ready;
         out_tag_d   = out_tag_q;
         out_data_d  = out_data_q;
         out_fault_d = out_fault_q;
      end
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push_s};
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop_s};
      fifo_d   = fifo_q;
      if (push_s) begin
         fifo_d[wr_ptr_q[PTR_W-1:0]] = '{op: in_op, size: in_size, sgn: in_signed,
                                         addr: in_addr, wdata: in_wdata, tag: in_tag};
      end else begin
         fifo_d = fifo_q;
      end
   end

   // Control and output registers; reset drops every queued and in-flight op.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_tag_q   <= '0;
         out_data_q  <= 64'd0;
         out_fault_q <= 1'b0;
         req_type_q  <= REQ_IDLE;
         req_addr_q  <= '0;
         req_data_q  <= 64'd0;
         req_be_q    <= 8'd0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         out_tag_q   <= out_tag_d;
         out_data_q  <= out_data_d;
         out_fault_q <= out_fault_d;
         req_type_q  <= req_type_d;
         req_addr_q  <= req_addr_d;
         req_data_q  <= req_data_d;
         req_be_q    <= req_be_d;
      end
   end

   // Payload storage needs no reset: pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

   assign in_ready       = !full_s;
   assign out_valid      = out_valid_q;
   assign out_tag        = out_tag_q;
   assign out_data       = out_data_q;
   assign out_fault      = out_fault_q;
   assign cache_req_type = req_type_q;
   assign req_addr       = req_addr_q;
   assign req_data       = req_data_q;
   assign req_be         = req_be_q;

endmodule

// File: tb/tb_mem_pipeline_q.sv
// Self-checking bench for mem_pipeline_q: directed scenarios plus a randomized run against a queue model.
`timescale 1ns/1ps
module tb_mem_pipeline_q;
   localparam int DEPTH = 4, TAG_W = 8, ADDR_W = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, in_valid, in_ready, in_signed, out_valid, out_ready, out_fault, mem_respcyc;
   logic [1:0] in_op, in_size, cache_req_type;
   logic [ADDR_W-1:0] in_addr, req_addr;
   logic [63:0] in_wdata, out_data, req_data, resp_data;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [7:0] req_be;

   mem_pipeline_q #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .out_data(out_data), .out_fault(out_fault), .cache_req_type(cache_req_type),
      .req_addr(req_addr), .req_data(req_data), .req_be(req_be), .mem_respcyc(mem_respcyc),
      .resp_data(resp_data));

   typedef struct {
      logic [1:0] op; logic [1:0] size; logic sgn;
      logic [63:0] addr; logic [63:0] wdata; logic [7:0] tag;
   } op_t;
   typedef struct { logic [7:0] tag; logic [63:0] data; logic fault; } res_t;

   op_t  ops[$];
   res_t res[$];
   int   n_pass = 0, n_total = 0;
   bit   cache_busy;
   int   cache_dly;

   function automatic logic [63:0] model_load(logic [63:0] word, int off, int size, bit sgn);
      int nb = 1 << size;
      logic [63:0] mask, v;
      mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (nb * 8)) - 64'd1);
      v = (word >> (off * 8)) & mask;
      if (sgn && v[nb*8-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic bit model_fault(op_t o);
`ifdef MEM_PIPE_ALIGN_CHK_EN
      return (o.op == 2'd1 || o.op == 2'd2) && ((o.addr % (64'd1 << o.size)) != 64'd0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_size = 2'd0; in_signed = 1'b0;
      in_addr = 64'd0; in_wdata = 64'd0; in_tag = 8'd0; out_ready = 1'b0;
      mem_respcyc = 1'b0; resp_data = 64'd0;
      tick(); tick();
      reset = 1'b0;
      ops.delete(); res.delete(); cache_busy = 1'b0;
   endtask

   task automatic offer(logic [1:0] op, logic [1:0] size, logic sgn, logic [63:0] addr,
                        logic [63:0] wdata, logic [7:0] tag);
      in_valid = 1'b1; in_op = op; in_size = size; in_signed = sgn;
      in_addr = addr; in_wdata = wdata; in_tag = tag;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if ({in_ready, out_valid, cache_req_type, req_be, out_fault} !== {1'b1, 1'b0, 2'd0, 8'd0, 1'b0})
         $display("FAIL reset_ctrl: got rdy=%b ov=%b type=%0d be=%h flt=%b want 1 0 0 00 0",
                  in_ready, out_valid, cache_req_type, req_be, out_fault);
      else n_pass++;
      n_total++;
      if ({out_tag, out_data} !== {8'd0, 64'd0})
         $display("FAIL reset_data: got tag=%h data=%h want 0 0", out_tag, out_data);
      else n_pass++;
   endtask

   task automatic load_case(string name, logic [1:0] size, logic sgn, logic [63:0] addr,
                            logic [63:0] word, logic [7:0] tag, logic [63:0] exp);
      out_ready = 1'b1;
      offer(2'd1, size, sgn, addr, 64'd0, tag);
      tick();
      n_total++;
      if ({cache_req_type, req_addr, req_be} !== {2'd1, addr & ~64'h7, 8'd0})
         $display("FAIL %s_req: got type=%0d addr=%h be=%h want 1 %h 00", name, cache_req_type,
                  req_addr, req_be, addr & ~64'h7);
      else n_pass++;
      mem_respcyc = 1'b1; resp_data = word;
      tick();
      mem_respcyc = 1'b0;
      n_total++;
      if ({out_valid, out_tag, out_data, out_fault} !== {1'b1, tag, exp, 1'b0})
         $display("FAIL %s_result: got v=%b tag=%h data=%h f=%b want 1 %h %h 0", name, out_valid,
                  out_tag, out_data, out_fault, tag, exp);
      else n_pass++;
      tick();
   endtask

   task automatic test_load();
      do_reset();
      load_case("load8", 2'd3, 1'b0, 64'h1000, 64'h1122334455667788, 8'h5A, 64'h1122334455667788);
      load_case("load1s", 2'd0, 1'b1, 64'h1003, 64'h0000000080000000, 8'h21, 64'hFFFFFFFFFFFFFF80);
      load_case("load1u", 2'd0, 1'b0, 64'h1003, 64'h0000000080000000, 8'h22, 64'h0000000000000080);
      load_case("load2s", 2'd1, 1'b1, 64'h2004, 64'h0000_8001_0000_0000, 8'h23, 64'hFFFFFFFFFFFF8001);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL load_consumed: got %b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_store();
      do_reset();
      out_ready = 1'b1;
      offer(2'd2, 2'd1, 1'b0, 64'h2006, 64'hBEEF, 8'h33);
      tick();
      for (int i = 0; i < 6; i++) begin
         n_total++;
         if ({cache_req_type, req_addr, req_be, req_data} !==
             {2'd2, 64'h2000, 8'hC0, 64'hBEEF000000000000})
            $display("FAIL store_req_hold%0d: got type=%0d addr=%h be=%h data=%h want 2 2000 c0 beef000000000000",
                     i, cache_req_type, req_addr, req_be, req_data);
         else n_pass++;
         mem_respcyc = (i == 5);
         tick();
      end
      mem_respcyc = 1'b0;
      n_total++;
      if ({out_valid, out_tag, out_data, cache_req_type} !== {1'b1, 8'h33, 64'd0, 2'd0})
         $display("FAIL store_result: got v=%b tag=%h data=%h type=%0d want 1 33 0 0",
                  out_valid, out_tag, out_data, cache_req_type);
      else n_pass++;
      tick();
   endtask

   task automatic test_fill();
      int accepted = 0;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < DEPTH + 3; i++) begin
         in_valid = 1'b1; in_op = 2'd1; in_size = 2'd3; in_signed = 1'b0;
         in_addr = 64'h100 * accepted; in_tag = 8'(accepted);
         if (in_ready) accepted++;
         tick();
      end
      in_valid = 1'b0;
      n_total++;
      if (accepted !== DEPTH || in_ready !== 1'b0)
         $display("FAIL fill_full: got accepted=%0d rdy=%b want %0d 0", accepted, in_ready, DEPTH);
      else n_pass++;
      for (int k = 0; k < DEPTH; k++) begin
         for (int w = 0; w < 6 && cache_req_type == 2'd0; w++) tick();
         n_total++;
         if (cache_req_type !== 2'd1 || req_addr !== 64'h100 * k)
            $display("FAIL fill_issue%0d: got type=%0d addr=%h want 1 %h", k, cache_req_type,
                     req_addr, 64'h100 * k);
         else n_pass++;
         mem_respcyc = 1'b1; resp_data = 64'hA0 + 64'(k);
         tick();
         mem_respcyc = 1'b0;
         n_total++;
         if ({out_valid, out_tag, out_data} !== {1'b1, 8'(k), 64'hA0 + 64'(k)})
            $display("FAIL fill_order%0d: got v=%b tag=%h data=%h want 1 %h %h", k, out_valid,
                     out_tag, out_data, 8'(k), 64'hA0 + 64'(k));
         else n_pass++;
      end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      offer(2'd0, 2'd0, 1'b0, 64'd0, 64'd0, 8'h11);
      offer(2'd1, 2'd3, 1'b0, 64'h3000, 64'd0, 8'h22);
      for (int i = 0; i < 4; i++) begin
         n_total++;
         if (out_valid !== 1'b1 || out_tag !== 8'h11 || cache_req_type !== 2'd0)
            $display("FAIL bp_stall%0d: got v=%b tag=%h type=%0d want 1 11 0", i, out_valid,
                     out_tag, cache_req_type);
         else n_pass++;
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_total++;
      if (out_valid !== 1'b0 || cache_req_type !== 2'd1 || req_addr !== 64'h3000)
         $display("FAIL bp_release: got v=%b type=%0d addr=%h want 0 1 3000", out_valid,
                  cache_req_type, req_addr);
      else n_pass++;
      mem_respcyc = 1'b1; resp_data = 64'h55;
      tick();
      mem_respcyc = 1'b0; out_ready = 1'b1;
      n_total++;
      if (out_valid !== 1'b1 || out_tag !== 8'h22 || out_data !== 64'h55)
         $display("FAIL bp_result: got v=%b tag=%h data=%h want 1 22 55", out_valid, out_tag, out_data);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b1;
      offer(2'd1, 2'd3, 1'b0, 64'h4000, 64'd0, 8'h01);
      offer(2'd2, 2'd3, 1'b0, 64'h4008, 64'h9, 8'h02);
      offer(2'd0, 2'd0, 1'b0, 64'd0, 64'd0, 8'h03);
      n_total++;
      if (cache_req_type !== 2'd1) $display("FAIL midrst_pre: got type=%0d want 1", cache_req_type);
      else n_pass++;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_total++;
      if ({cache_req_type, in_ready, out_valid, req_be} !== {2'd0, 1'b1, 1'b0, 8'd0})
         $display("FAIL midrst_clear: got type=%0d rdy=%b v=%b be=%h want 0 1 0 00",
                  cache_req_type, in_ready, out_valid, req_be);
      else n_pass++;
      mem_respcyc = 1'b1; resp_data = 64'hDEAD;
      tick();
      mem_respcyc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if (out_valid !== 1'b0 || cache_req_type !== 2'd0)
            $display("FAIL midrst_quiet%0d: got v=%b type=%0d want 0 0", i, out_valid, cache_req_type);
         else n_pass++;
         tick();
      end
   endtask

`ifdef MEM_PIPE_ALIGN_CHK_EN
   task automatic test_align();
      do_reset();
      out_ready = 1'b1;
      offer(2'd1, 2'd2, 1'b0, 64'h1002, 64'd0, 8'h77);
      n_total++;
      if (cache_req_type !== 2'd0) $display("FAIL align_noreq: got type=%0d want 0", cache_req_type);
      else n_pass++;
      mem_respcyc = 1'b1; resp_data = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      mem_respcyc = 1'b0;
      n_total++;
      if ({out_valid, out_tag, out_fault, out_data, cache_req_type} !== {1'b1, 8'h77, 1'b1, 64'd0, 2'd0})
         $display("FAIL align_fault: got v=%b tag=%h f=%b data=%h type=%0d want 1 77 1 0 0",
                  out_valid, out_tag, out_fault, out_data, cache_req_type);
      else n_pass++;
      tick();
   endtask
`endif

   // One cycle of the randomized run: model bookkeeping, cache responder, sink and source.
   task automatic random_cycle(bit allow_in);
      op_t o;
      res_t r;
      int nb, off;
      while (ops.size() > 0 && (ops[0].op == 2'd0 || model_fault(ops[0]))) begin
         o = ops.pop_front();
         res.push_back('{tag: o.tag, data: 64'd0, fault: model_fault(o)});
      end
      mem_respcyc = 1'b0;
      resp_data = {$urandom, $urandom};
      if (cache_req_type != 2'd0) begin
         n_total++;
         if (ops.size() == 0) begin
            $display("FAIL rand_spurious_req: got type=%0d want 0", cache_req_type);
         end else begin
            o = ops[0];
            if (cache_req_type !== o.op || req_addr !== (o.addr & ~64'h7) ||
                req_be !== ((o.op == 2'd2) ? 8'((((1 << (1 << o.size)) - 1) << o.addr[2:0])) : 8'd0) ||
                (o.op == 2'd2 && req_data !== (o.wdata << (o.addr[2:0] * 8))))
               $display("FAIL rand_req: got type=%0d addr=%h be=%h data=%h want op=%0d addr=%h wdata=%h size=%0d",
                        cache_req_type, req_addr, req_be, req_data, o.op, o.addr & ~64'h7, o.wdata, o.size);
            else n_pass++;
            if (!cache_busy) begin cache_busy = 1'b1; cache_dly = $urandom_range(0, 3); end
            if (cache_dly == 0) begin
               mem_respcyc = 1'b1;
               cache_busy = 1'b0;
               o = ops.pop_front();
               res.push_back('{tag: o.tag, fault: 1'b0,
                               data: (o.op == 2'd1) ? model_load(resp_data, o.addr[2:0], o.size, o.sgn) : 64'd0});
            end else begin
               cache_dly--;
            end
         end
      end else begin
         mem_respcyc = ($urandom_range(0, 7) == 0);
      end
      out_ready = allow_in ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid && out_ready) begin
         n_total++;
         if (res.size() == 0) begin
            $display("FAIL rand_extra_result: got tag=%h want none", out_tag);
         end else begin
            r = res.pop_front();
            if (out_tag !== r.tag || out_data !== r.data || out_fault !== r.fault)
               $display("FAIL rand_result: got tag=%h data=%h f=%b want %h %h %b", out_tag, out_data,
                        out_fault, r.tag, r.data, r.fault);
            else n_pass++;
         end
      end
      in_valid = allow_in && ($urandom_range(0, 1) == 1);
      in_op = 2'($urandom_range(0, 3)); in_size = 2'($urandom_range(0, 3));
      in_signed = 1'($urandom_range(0, 1));
      nb = 1 << in_size;
      off = $urandom_range(0, 8 - nb);
      in_addr = ({$urandom, $urandom} & ~64'h7) | 64'(off);
      in_wdata = {$urandom, $urandom}; in_tag = 8'($urandom);
      if (in_valid && in_ready)
         ops.push_back('{op: in_op, size: in_size, sgn: in_signed, addr: in_addr, wdata: in_wdata, tag: in_tag});
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++) random_cycle(1'b1);
      for (int i = 0; i < 300 && (ops.size() + res.size() > 0 || out_valid); i++) random_cycle(1'b0);
      n_total++;
      if (ops.size() + res.size() != 0 || out_valid !== 1'b0)
         $display("FAIL rand_drain: got ops=%0d res=%0d v=%b want 0 0 0", ops.size(), res.size(), out_valid);
      else n_pass++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_load();
      test_store();
      test_fill();
      test_backpressure();
      test_reset_mid();
`ifdef MEM_PIPE_ALIGN_CHK_EN
      test_align();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
